// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline memory stage.
package pipe_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // Word-align a byte address.
    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipemwreg.sv
// MEM/WB pipeline register with async clear and bubble insertion.
module pipemwreg
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              clrn,
    input  logic              i_bubble,
    input  logic              i_wreg,
    input  logic              i_m2reg,
    input  logic              i_mo_we,
    input  logic [WORD_W-1:0] i_mo,
    input  logic [WORD_W-1:0] i_alu,
    input  logic [REG_W-1:0]  i_rn,
    output logic              o_wreg,
    output logic              o_m2reg,
    output logic [WORD_W-1:0] o_mo,
    output logic [WORD_W-1:0] o_alu,
    output logic [REG_W-1:0]  o_rn
);

    // A bubble kills the control bits only; data fields keep their value.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            o_wreg  <= 1'b0;
            o_m2reg <= 1'b0;
            o_mo    <= '0;
            o_alu   <= '0;
            o_rn    <= '0;
        end else if (i_bubble) begin
            o_wreg  <= 1'b0;
            o_m2reg <= 1'b0;
        end else begin
            o_wreg  <= i_wreg;
            o_m2reg <= i_m2reg;
            o_alu   <= i_alu;
            o_rn    <= i_rn;
            if (i_mo_we) o_mo <= i_mo;
        end
    end

endmodule

// File: rtl/pipemem_ctrl.sv
// Memory-stage controller: dreq/dack data-memory handshake, pipeline stall, MEM/WB register.
// Optional ACCESS timeout with merr pulse is built when PIPEMEM_TIMEOUT_EN is defined.
module pipemem_ctrl
    import pipe_pkg::*;
`ifdef PIPEMEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = pipe_pkg::TIMEOUT_DEF
)
`endif
(
    input  logic              clk,
    input  logic              clrn,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic              mwmem,
    input  logic [WORD_W-1:0] malu,
    input  logic [WORD_W-1:0] mb,
    input  logic [REG_W-1:0]  mrn,
    output logic              dreq,
    output logic              dwe,
    output logic [WORD_W-1:0] daddr,
    output logic [WORD_W-1:0] dwdata,
    input  logic              dack,
    input  logic [WORD_W-1:0] drdata,
    output logic              mstall,
    output logic              merr,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [WORD_W-1:0] wmo,
    output logic [WORD_W-1:0] walu,
    output logic [REG_W-1:0]  wrn
);

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic              w_memop;
    logic              w_timeout;
    logic              w_wb_wreg;
    logic              w_wb_m2reg;
    logic              w_wb_mo_we;
    logic [WORD_W-1:0] w_wb_alu;
    logic [REG_W-1:0]  w_wb_rn;

    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_rdata;
    logic [REG_W-1:0]  r_rn;
    logic              r_wreg;
    logic              r_m2reg;

    assign w_memop = mm2reg | mwmem;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state, stall and MEM/WB input selection.
    always_comb begin
        w_next     = r_state;
        mstall     = 1'b0;
        w_wb_wreg  = mwreg;
        w_wb_m2reg = 1'b0;
        w_wb_mo_we = 1'b0;
        w_wb_alu   = malu;
        w_wb_rn    = mrn;
        case (r_state)
            IDLE: begin
                if (w_memop) begin
                    mstall = 1'b1;
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                mstall = 1'b1;
                if (dack || w_timeout) w_next = DONE;
            end
            DONE: begin
                w_next     = IDLE;
                w_wb_wreg  = r_wreg;
                w_wb_m2reg = r_m2reg;
                w_wb_mo_we = 1'b1;
                w_wb_alu   = r_addr;
                w_wb_rn    = r_rn;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latches; the illegal load+store combination is handled as a store.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dreq    <= 1'b0;
            dwe     <= 1'b0;
            daddr   <= '0;
            dwdata  <= '0;
            r_addr  <= '0;
            r_rdata <= '0;
            r_rn    <= '0;
            r_wreg  <= 1'b0;
            r_m2reg <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_memop) begin
                        dreq    <= 1'b1;
                        dwe     <= mwmem;
                        daddr   <= word_addr(malu);
                        dwdata  <= mb;
                        r_addr  <= malu;
                        r_rn    <= mrn;
                        r_wreg  <= mwreg;
                        r_m2reg <= mm2reg & ~mwmem;
                    end
                end
                ACCESS: begin
                    if (dack) begin
                        dreq <= 1'b0;
                        if (!dwe) r_rdata <= drdata;
                    end else if (w_timeout) begin
                        dreq    <= 1'b0;
                        r_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPEMEM_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = (r_state == ACCESS) && (r_cnt == CNT_W'(TIMEOUT - 1));

    // Counts ACCESS cycles; an ack in the last allowed cycle still wins.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_cnt <= '0;
            merr  <= 1'b0;
        end else begin
            merr <= w_timeout & ~dack;
            if (r_state == ACCESS) r_cnt <= r_cnt + CNT_W'(1);
            else                   r_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign merr      = 1'b0;
`endif

    pipemwreg u_mwreg (
        .clk      (clk),
        .clrn     (clrn),
        .i_bubble (mstall),
        .i_wreg   (w_wb_wreg),
        .i_m2reg  (w_wb_m2reg),
        .i_mo_we  (w_wb_mo_we),
        .i_mo     (r_rdata),
        .i_alu    (w_wb_alu),
        .i_rn     (w_wb_rn),
        .o_wreg   (wwreg),
        .o_m2reg  (wm2reg),
        .o_mo     (wmo),
        .o_alu    (walu),
        .o_rn     (wrn)
    );

endmodule

// File: tb/tb_pipemem_ctrl.sv
// Scoreboard bench for pipemem_ctrl: memory responder, stall/handshake checks, MEM/WB scoreboard.
module tb_pipemem_ctrl;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        mwreg = 1'b0, mm2reg = 1'b0, mwmem = 1'b0;
    logic [31:0] malu = '0, mb = '0;
    logic [4:0]  mrn = '0;
    logic        dreq, dwe, dack = 1'b0;
    logic [31:0] daddr, dwdata, drdata = '0;
    logic        mstall, merr, wwreg, wm2reg;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;

`ifdef PIPEMEM_TIMEOUT_EN
    localparam int STORE_WAITS = 3;
`else
    localparam int STORE_WAITS = 4;
`endif

    always #5 clk = ~clk;

`ifdef PIPEMEM_TIMEOUT_EN
    pipemem_ctrl #(.TIMEOUT(4)) u_dut (
        .clk(clk), .clrn(clrn),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mrn(mrn),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .dack(dack), .drdata(drdata),
        .mstall(mstall), .merr(merr),
        .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn)
    );
`else
    pipemem_ctrl u_dut (
        .clk(clk), .clrn(clrn),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mrn(mrn),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .dack(dack), .drdata(drdata),
        .mstall(mstall), .merr(merr),
        .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn)
    );
`endif

    typedef struct {
        logic        wreg;
        logic        m2reg;
        logic [31:0] mo;
        logic [31:0] alu;
        logic [4:0]  rn;
    } wb_t;

    wb_t         sbq[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] last_rd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".dreq"},   32'(dreq),   0);
        check({tag, ".dwe"},    32'(dwe),    0);
        check({tag, ".daddr"},  daddr,       0);
        check({tag, ".dwdata"}, dwdata,      0);
        check({tag, ".mstall"}, 32'(mstall), 0);
        check({tag, ".merr"},   32'(merr),   0);
        check({tag, ".wwreg"},  32'(wwreg),  0);
        check({tag, ".wm2reg"}, 32'(wm2reg), 0);
        check({tag, ".wmo"},    wmo,         0);
        check({tag, ".walu"},   walu,        0);
        check({tag, ".wrn"},    32'(wrn),    0);
    endtask

    // Drives one EX/MEM instruction from a negedge and runs it to its MEM/WB write.
    task automatic run_op(input logic wr, input logic m2, input logic wm,
                          input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                          input int waits, input logic [31:0] rd, input bit nack, input bit spur);
        wb_t  e, g;
        logic memop;
        int   acc, stalls, exp_acc;
        bit   done;
        logic [31:0] exp_addr;
        memop = m2 | wm;
        exp_addr = {alu[31:2], 2'b00};
        mwreg = wr; mm2reg = m2; mwmem = wm; malu = alu; mb = b; mrn = rn;
        if (memop && !wm) last_rd = nack ? 32'h0 : rd;
        e.wreg = wr; e.m2reg = m2 & ~wm; e.mo = last_rd; e.alu = alu; e.rn = rn;
        sbq.push_back(e);
        exp_acc = !memop ? 0 : (nack ? 4 : waits + 1);
        acc = 0; stalls = 0; done = 1'b0;
        if (!memop && spur) begin dack = 1'b1; drdata = rd; end
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (dreq) begin
                acc++;
                check("dwe", 32'(dwe), 32'(wm));
                check("daddr", daddr, exp_addr);
                check("dwdata", dwdata, b);
                if (!nack && acc == waits + 1) begin dack = 1'b1; drdata = rd; end
            end
            if (mstall) stalls++;
            else begin
                check("merr", 32'(merr), 32'(nack));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            dack = 1'b0;
            drdata = $urandom;
            if (done) begin
                g = sbq.pop_front();
                check("wwreg", 32'(wwreg), 32'(g.wreg));
                check("wm2reg", 32'(wm2reg), 32'(g.m2reg));
                check("wmo", wmo, g.mo);
                check("walu", walu, g.alu);
                check("wrn", 32'(wrn), 32'(g.rn));
            end
            @(negedge clk);
        end
        if (!done) check("hang", 1, 0);
        check("stalls", 32'(stalls), memop ? 32'(exp_acc + 1) : 0);
        check("access", 32'(acc), 32'(exp_acc));
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        clrn = 1'b1;

        run_op(1, 0, 0, 32'h10, 32'h0, 5'd5, 0, 0, 0, 0);
        run_op(1, 1, 0, 32'h104, 32'h0, 5'd7, 0, 32'hCAFEF00D, 0, 0);
        run_op(0, 0, 1, 32'h203, 32'h55AA55AA, 5'd0, STORE_WAITS, 32'h0, 0, 0);
        run_op(1, 1, 0, 32'h300, 32'h0, 5'd9, 1, 32'h12345678, 0, 0);
        run_op(1, 0, 0, 32'h44, 32'h0, 5'd3, 0, 32'hDEADBEEF, 0, 1);
        run_op(1, 1, 1, 32'h8, 32'h77, 5'd4, 2, 32'hBADBAD00, 0, 0);

        for (int i = 0; i < 6; i++) begin
            int k;
            k = int'($urandom_range(0, 2));
            run_op(1'b1, k == 1, k == 2, $urandom, $urandom, 5'($urandom),
                   int'($urandom_range(0, 3)), $urandom, 0, 0);
        end

        // Abandon a load mid-ACCESS with an asynchronous reset.
        mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h400; mrn = 5'd2;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("mid.dreq_before", 32'(dreq), 1);
        clrn = 1'b0;
        mwreg = 0; mm2reg = 0; mwmem = 0; malu = '0; mb = '0; mrn = '0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        clrn = 1'b1;
        sbq.delete();
        last_rd = '0;
        run_op(1, 0, 0, 32'h20, 32'h0, 5'd6, 0, 0, 0, 0);
        run_op(1, 1, 0, 32'h500, 32'h0, 5'd8, 0, 32'hA5A5A5A5, 0, 0);

`ifdef PIPEMEM_TIMEOUT_EN
        run_op(1, 1, 0, 32'h600, 32'h0, 5'd10, 0, 32'h11112222, 1, 0);
        run_op(1, 1, 0, 32'h604, 32'h0, 5'd11, 3, 32'h33334444, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
